// File: rtl/chunk_adder_seq.sv
// -----------------------------------------------------------------------------
// chunk_adder_seq
//
// Multi-cycle adder/subtractor. Two WIDTH-bit operands are added CHUNK bits
// per clock, least-significant chunk first. A ripple carry is held between
// chunks. A start/busy/done handshake frames each operation. The result,
// carry-out and signed-overflow flag are registered and held until the next
// completion.
//
// Optional feature macro:
//   CHUNK_ADDER_SAT_EN - when defined, a signed overflow clamps S to the
//                        signed limit that matches the sign of operand A.
//                        When undefined, S wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH  operand/result width (must be a multiple of CHUNK)
//   CHUNK  bits processed per clock
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request; sampled only in IDLE or DONE
//   sub    0: A+B+Cin, 1: A-B (Cin ignored); latched at start
//   A, B   operands; latched at start
//   Cin    carry-in for add; latched at start
//   busy   high while chunks are being processed
//   done   one-cycle completion pulse
//   S      registered result
//   Cout   registered carry out of the MSB (sub: 1 = no borrow)
//   OV     registered signed overflow
// -----------------------------------------------------------------------------
module chunk_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OV
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;   // already inverted for subtraction
    logic             carry;
    logic [WIDTH-1:0] work;    // partial sum, never exposed on S

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] next_work;
    logic             ov_next;
    logic [WIDTH-1:0] result_next;

`ifdef CHUNK_ADDER_SAT_EN
    // Clamp to the signed limit on overflow. Overflow only happens when both
    // operands share a sign, so the sign of A picks the limit.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] sum,
        input logic             ovf,
        input logic             a_msb
    );
        logic signed [WIDTH-1:0] lim;
        if (!ovf) begin
            return sum;
        end
        if (a_msb) begin
            lim = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            lim = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return lim;
    endfunction
`endif

    // One ripple slice. It works on the chunk selected by idx.
    always_comb begin
        a_chunk   = a_reg[int'(idx)*CHUNK +: CHUNK];
        b_chunk   = b_reg[int'(idx)*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        next_work = work;
        next_work[int'(idx)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        // The overflow flag is only meaningful on the final chunk. At that
        // point next_work holds the complete sum.
        ov_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                  (next_work[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef CHUNK_ADDER_SAT_EN
        result_next = saturate(next_work, ov_next, a_reg[WIDTH-1]);
`else
        result_next = next_work;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            work  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            OV    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    // A start in DONE is treated like a start in IDLE, so
                    // operations can be issued back-to-back.
                    if (start) begin
                        a_reg <= A;
                        b_reg <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : Cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work  <= next_work;
                    carry <= chunk_sum[CHUNK];
                    if (idx == LAST_IDX) begin
                        S     <= result_next;
                        Cout  <= chunk_sum[CHUNK];
                        OV    <= ov_next;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_chunk_adder_seq
//
// Scoreboard bench for chunk_adder_seq with default parameters (16/4).
// The stimulus pushes the hand-computed {S, Cout, OV} of each operation into
// a queue. A monitor pops one entry on every done pulse and compares it.
// Handshake timing is also checked directly from the stimulus side.
// -----------------------------------------------------------------------------
module tb_chunk_adder_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OV;

    int checks = 0;
    int errors = 0;

    logic [WIDTH+1:0] exp_q[$];
    string            name_q[$];

    chunk_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .S    (S),
        .Cout (Cout),
        .OV   (OV)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH+1:0] pk(input logic [WIDTH-1:0] s,
                                            input logic c, input logic o);
        return {s, c, o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: each done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got S=%h Cout=%b OV=%b expected no completion",
                         S, Cout, OV);
            end else begin
                logic [WIDTH+1:0] e;
                string            n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if ({S, Cout, OV} !== e) begin
                    errors++;
                    $display("FAIL %s: got S=%h Cout=%b OV=%b expected S=%h Cout=%b OV=%b",
                             n, S, Cout, OV, e[WIDTH+1:2], e[1], e[0]);
                end
            end
        end
    end

    // One complete operation with handshake timing checks. The operand
    // inputs are scrambled right after the start edge to show they are
    // latched.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sb,
                         input logic [WIDTH+1:0] e, input string nm);
        @(posedge clk); #1;
        A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;                 // t0
        start = 1'b0; A = ~a; B = ~b; Cin = ~cin; sub = ~sb;
        chk({nm, "_busy_t0"}, 32'(busy), 32'd1);
        for (int i = 1; i < N; i++) begin
            @(posedge clk); #1;
            chk({nm, "_busy_run"}, 32'({busy, done}), 32'b10);
        end
        @(posedge clk); #1;                 // tN
        chk({nm, "_done_tN"}, 32'({busy, done}), 32'b01);
        @(posedge clk); #1;
        chk({nm, "_done_clear"}, 32'({busy, done}), 32'b00);
    endtask

    logic [WIDTH-1:0] sat_pos_s;
    logic [WIDTH-1:0] sat_neg_s;
    logic [WIDTH-1:0] sub_ov_s;

    initial begin
`ifdef CHUNK_ADDER_SAT_EN
        sat_pos_s = 16'h7FFF;
        sat_neg_s = 16'h8000;
        sub_ov_s  = 16'h8000;
`else
        sat_pos_s = 16'h8000;
        sat_neg_s = 16'h0000;
        sub_ov_s  = 16'h7FFF;
`endif
        // Reset state.
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", 32'({busy, done, S, Cout, OV}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Arithmetic vectors.
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, pk(16'h5555, 1'b0, 1'b0), "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(16'h0000, 1'b1, 1'b0), "add_wrap");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, pk(16'h0001, 1'b0, 1'b0), "add_cin");
        do_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, pk(16'h1000, 1'b0, 1'b0), "chunk_carry");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(sat_pos_s, 1'b0, 1'b1), "ov_pos");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, pk(sat_neg_s, 1'b1, 1'b1), "ov_neg");
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, pk(16'hFFFE, 1'b0, 1'b0), "sub_borrow");
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, pk(16'h0002, 1'b1, 1'b0), "sub_cin_ignored");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, pk(sub_ov_s, 1'b1, 1'b1), "sub_ov");

        // Asynchronous reset after two chunk edges discards the operation.
        @(posedge clk); #1;
        A = 16'h1111; B = 16'h1111; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;    // t0
        @(posedge clk);                     // t1
        @(posedge clk);                     // t2
        #2 rst = 1'b1;
        #1;
        chk("rst_midrun_outputs", 32'({busy, done, S, Cout, OV}), 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        repeat (N + 2) @(posedge clk);
        do_op(16'h0102, 16'h0304, 1'b0, 1'b0, pk(16'h0406, 1'b0, 1'b0), "after_reset");

        // start held high during RUN while A and B change.
        @(posedge clk); #1;
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        exp_q.push_back(pk(16'h3333, 1'b0, 1'b0));
        name_q.push_back("start_held");
        @(posedge clk); #1;                 // t0
        A = 16'hFFFF; B = 16'hFFFF;
        repeat (N - 1) @(posedge clk);      // t1..t3 with start still high
        #1 start = 1'b0;
        @(posedge clk); #1;                 // tN
        chk("start_held_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("start_held_idle", 32'({busy, done}), 32'b00);

        // Back-to-back: a start in the DONE cycle launches the next op.
        @(posedge clk); #1;
        A = 16'h0001; B = 16'h0002; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        exp_q.push_back(pk(16'h0003, 1'b0, 1'b0));
        name_q.push_back("b2b_first");
        @(posedge clk); #1 start = 1'b0;    // t0
        repeat (N) @(posedge clk);
        #1;                                 // DONE cycle
        chk("b2b_first_done", 32'(done), 32'd1);
        A = 16'h0100; B = 16'h0200; start = 1'b1;
        exp_q.push_back(pk(16'h0300, 1'b0, 1'b0));
        name_q.push_back("b2b_second");
        @(posedge clk); #1 start = 1'b0;    // t0 of the second op
        chk("b2b_busy", 32'({busy, done}), 32'b10);
        chk("b2b_hold_t0", 32'(S), 32'h0003);
        for (int i = 1; i < N; i++) begin
            @(posedge clk); #1;
            chk("b2b_hold_run", 32'(S), 32'h0003);
        end
        @(posedge clk); #1;
        chk("b2b_second_done", 32'({done, S}), {15'd0, 1'b1, 16'h0300});

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
